// File: rtl/ocx_pkg.sv
// ocx_pkg: shared widths, types and command record for the OpenCAPI request tag manager
package ocx_pkg;
  localparam int NSTRMS = 64;
  localparam int SID_W = $clog2(NSTRMS);
  localparam int NTAGS = 32;
  localparam int TAG_W = $clog2(NTAGS);
  localparam int ADDR_W = 64;
  localparam int CNT_W = 32;
  localparam int CL_BYTES_LOG2 = 7;
  typedef logic [SID_W-1:0] sid_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    tag_t tag;
    addr_t addr;
  } cmd_t;
endpackage

// File: rtl/ocx_req_tag_mgr_tag_pool.sv
// tag_pool: free-tag bitmap with lowest-index allocation and occupancy count
module tag_pool #(
  parameter int ntags = 32,
  parameter int tag_width = $clog2(ntags)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_i,
  input  logic                 free_i,
  input  logic [tag_width-1:0] free_tag_i,
  output logic                 any_free_o,
  output logic [tag_width-1:0] alloc_tag_o,
  output logic                 tag_busy_o,
  output logic [tag_width:0]   count_o
);
  logic [ntags-1:0] free_q, free_d;
  logic [tag_width:0] count_q, count_d;
  logic rel;
  always_comb begin
    alloc_tag_o = '0;
    for (int i = ntags - 1; i >= 0; i--) if (free_q[i]) alloc_tag_o = tag_width'(i);
  end
  assign any_free_o = |free_q;
  assign tag_busy_o = ~free_q[free_tag_i];
  // freeing an already-free tag is ignored so the count stays consistent
  assign rel = free_i & tag_busy_o;
  always_comb begin
    free_d = free_q;
    if (alloc_i) free_d[alloc_tag_o] = 1'b0;
    if (rel) free_d[free_tag_i] = 1'b1;
    count_d = count_q + {{tag_width{1'b0}}, alloc_i} - {{tag_width{1'b0}}, rel};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      free_q <= '1;
      count_q <= '0;
    end else begin
      free_q <= free_d;
      count_q <= count_d;
    end
  end
  assign count_o = count_q;
endmodule

// File: rtl/ocx_req_tag_mgr.sv
// ocx_req_tag_mgr: turns per-stream line requests into tagged host reads and maps responses back to streams
module ocx_req_tag_mgr
  import ocx_pkg::*;
#(
  parameter int nstrms = NSTRMS,
  parameter int sid_width = $clog2(nstrms),
  parameter int ntags = NTAGS,
  parameter int tag_width = $clog2(ntags),
  parameter int addr_width = ADDR_W,
  parameter int cnt_width = CNT_W,
  parameter int cl_bytes_log2 = CL_BYTES_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_v,
  output logic                  i_req_r,
  input  logic [sid_width-1:0]  i_req_sid,
  output logic                  o_cmd_v,
  input  logic                  o_cmd_r,
  output logic [tag_width-1:0]  o_cmd_tag,
  output logic [addr_width-1:0] o_cmd_addr,
  input  logic                  i_resp_v,
  output logic                  i_resp_r,
  input  logic [tag_width-1:0]  i_resp_tag,
  output logic                  o_rsp_v,
  input  logic                  o_rsp_r,
  output logic [sid_width-1:0]  o_rsp_sid,
  input  logic                  i_cfg_v,
  input  logic [sid_width-1:0]  i_cfg_sid,
  input  logic [addr_width-1:0] i_cfg_addr,
  input  logic                  i_clr_v,
  input  logic [sid_width-1:0]  i_clr_sid,
  output logic [tag_width:0]    o_outstanding
);
  logic [addr_width-1:0] base_q [nstrms];
  logic [cnt_width-1:0] cnt_q [nstrms];
  logic [sid_width-1:0] sid_tbl_q [ntags];
  logic cmd_v_q, rsp_v_q;
  cmd_t cmd_q;
  sid_t rsp_sid_q;
  logic any_free, req_acc, resp_acc, tag_busy;
  logic [tag_width-1:0] alloc_tag;
  logic [addr_width-1:0] req_addr;
  assign i_req_r = (~cmd_v_q | o_cmd_r) & any_free;
  assign req_acc = i_req_v & i_req_r;
  assign i_resp_r = ~rsp_v_q | o_rsp_r;
  assign resp_acc = i_resp_v & i_resp_r;
  assign req_addr = base_q[i_req_sid] + (addr_width'(cnt_q[i_req_sid]) << cl_bytes_log2);
  tag_pool #(.ntags(ntags), .tag_width(tag_width)) u_pool (
    .clk(clk),
    .reset(reset),
    .alloc_i(req_acc),
    .free_i(resp_acc),
    .free_tag_i(i_resp_tag),
    .any_free_o(any_free),
    .alloc_tag_o(alloc_tag),
    .tag_busy_o(tag_busy),
    .count_o(o_outstanding)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_v_q <= 1'b0;
      cmd_q <= '0;
      rsp_v_q <= 1'b0;
      rsp_sid_q <= '0;
      for (int i = 0; i < nstrms; i++) begin
        base_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      for (int i = 0; i < ntags; i++) sid_tbl_q[i] <= '0;
    end else begin
      cmd_v_q <= req_acc | (cmd_v_q & ~o_cmd_r);
      rsp_v_q <= resp_acc | (rsp_v_q & ~o_rsp_r);
      if (req_acc) begin
        cmd_q <= '{tag: alloc_tag, addr: req_addr};
        cnt_q[i_req_sid] <= cnt_q[i_req_sid] + cnt_width'(1);
        sid_tbl_q[alloc_tag] <= i_req_sid;
      end
      // a clear landing with a request for the same stream overrides its increment
      if (i_clr_v) cnt_q[i_clr_sid] <= '0;
      if (i_cfg_v) base_q[i_cfg_sid] <= i_cfg_addr;
      if (resp_acc) rsp_sid_q <= sid_tbl_q[i_resp_tag];
    end
  end
  assign o_cmd_v = cmd_v_q;
  assign o_cmd_tag = cmd_q.tag;
  assign o_cmd_addr = cmd_q.addr;
  assign o_rsp_v = rsp_v_q;
  assign o_rsp_sid = rsp_sid_q;
  resp_tag_busy: assert property (@(posedge clk) disable iff (reset) resp_acc |-> tag_busy);
endmodule

// File: doc/ocx_req_tag_mgr.md
Name: ocx_req_tag_mgr

Overview:
- Sits between the stream-buffer top level and the OpenCAPI 3.0 host command/response path.
- Consumes per-stream cacheline requests (sid only) and issues host read commands carrying a tag and a byte address.
- Byte address is computed per stream as base + line counter × line size.
- Maps host responses back from tag to sid and returns them on the sid-level response interface.

Parameters:
- nstrms, 64, number of streams
- sid_width, $clog2(nstrms), stream id width
- ntags, 32, outstanding host read tags
- tag_width, $clog2(ntags), tag width
- addr_width, 64, host byte address width
- cnt_width, 32, per-stream cacheline counter width
- cl_bytes_log2, 7, log2 of host line size in bytes (128 B)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req_v  in  1  cacheline request valid
- i_req_r  out  1  request ready
- i_req_sid  in  sid_width  requesting stream
- o_cmd_v  out  1  host read command valid
- o_cmd_r  in  1  host command ready
- o_cmd_tag  out  tag_width  command tag
- o_cmd_addr  out  addr_width  command byte address
- i_resp_v  in  1  host response valid
- i_resp_r  out  1  host response ready
- i_resp_tag  in  tag_width  response tag
- o_rsp_v  out  1  sid response valid
- o_rsp_r  in  1  sid response ready
- o_rsp_sid  out  sid_width  stream owning the response
- i_cfg_v  in  1  base address write strobe (always accepted)
- i_cfg_sid  in  sid_width  stream being configured
- i_cfg_addr  in  addr_width  new base, line aligned
- i_clr_v  in  1  functional stream clear strobe (always accepted)
- i_clr_sid  in  sid_width  stream to clear
- o_outstanding  out  tag_width+1  tags currently in use

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset:
  - All tags free.
  - o_cmd_v=0, o_rsp_v=0, o_outstanding=0.
  - All base registers and line counters = 0.
  - Other outputs: don't-care when valid is low; tie to 0.
- Tag pool:
  - Registered free bitmap.
  - Allocation always takes the lowest-index free tag, from the registered bitmap.
- Request path, 1-cycle latency:
  - i_req_r = (~o_cmd_v | o_cmd_r) & any_free.
  - On accept:
    - o_cmd register loads tag = lowest free.
    - addr = base[sid] + (cnt[sid] << cl_bytes_log2), modulo 2^addr_width.
    - cnt[sid] increments, wrapping modulo 2^cnt_width.
    - sid_tbl[tag] = sid.
    - Tag is marked busy.
  - o_cmd holds stable while o_cmd_v & ~o_cmd_r.
  - No free tag (ntags outstanding): i_req_r=0; o_cmd may still drain.
- Response path, 1-cycle latency:
  - i_resp_r = ~o_rsp_v | o_rsp_r.
  - On accept: o_rsp_sid = sid_tbl[i_resp_tag], o_rsp_v=1, tag returns to the free bitmap.
  - A freed tag is allocatable from the next cycle, never the same cycle.
  - Response to a free tag is a protocol error: assertion only; design frees nothing and still emits o_rsp with stale sid_tbl content.
- o_outstanding:
  - Popcount of busy tags.
  - Alloc and free in the same cycle leave it unchanged.
  - Range 0..ntags.
- Config:
  - i_cfg_v writes base[i_cfg_sid] at the clock edge.
  - A same-cycle request for the same sid uses the old base.
- Clear:
  - i_clr_v sets cnt[i_clr_sid]=0.
  - A same-cycle accepted request for the same sid uses the old count, and the counter ends at 0 (clear wins).
  - Outstanding tags of that sid are not cancelled; their responses still return with that sid.
- Reset mid-operation: all in-flight state is discarded; any host responses arriving after reset are the system's responsibility.

Decomposition:
- Shared package ocx_pkg:
  - sid_t, tag_t, addr_t, cnt_t typedefs.
  - CL_BYTES_LOG2 constant.
  - cmd_t struct {tag, addr}.
- One natural sub-module, tag_pool: free bitmap, lowest-free priority encoder, alloc/free ports, occupancy count.
- Address arithmetic and the sid table stay in the top.

Test Plan:
- Base load and sequential addressing:
  - Stimulus: reset; cfg sid 5 base 0x1000; three requests sid 5, o_cmd_r=1.
  - Expected: cmds tag 0/1/2, addr 0x1000/0x1080/0x1100, one per cycle, o_outstanding=3.
- Out-of-order responses:
  - Stimulus: requests sid 3 then sid 9 (tags 0, 1); responses tag 1 then tag 0.
  - Expected: o_rsp_sid 9 then 3, o_outstanding back to 0.
- Tag exhaustion:
  - Stimulus: 32 requests with no responses.
  - Expected: i_req_r=0 after 32nd accept.
  - Follow-up: response tag 17 → i_req_r=1 next cycle, next cmd uses tag 17.
- Backpressure:
  - Stimulus: o_cmd_r=0 for 5 cycles with request pending.
  - Expected: o_cmd_v/tag/addr stable, only one tag consumed.
  - Stimulus: o_rsp_r=0.
  - Expected: i_resp_r=0 while o_rsp_v=1.
- Clear and config collisions:
  - Stimulus: sid 2 at cnt 4; i_clr sid 2 and request sid 2 in the same cycle.
  - Expected: cmd addr = base+0x200, next request addr = base+0x0.
  - Stimulus: cfg + request same cycle.
  - Expected: request uses old base.
- Reset mid-operation:
  - Stimulus: 10 tags outstanding, assert reset.
  - Expected: o_outstanding=0, next request gets tag 0, addr = 0x0.
